gemm_uop_decode: RTL and testbench
==================================

# gemm_uop_decode

Consumer side of the micro-op fetch path in the GEMM core. It accepts a stream of micro-op addresses (upc) with their loop offsets from the uop fetch sequencer and reads each 32-bit micro-op from the uop SRAM. It unpacks the accumulator, input and weight indices, adds the outer and inner loop offsets, and presents the final buffer indices to the GEMM datapath over a valid/ready handshake. The pipeline has 2 stages, issues 1 index triple per cycle and stalls completely on backpressure.

## Interface
- Parameters: none. All widths come from the shared package.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline clear; applies between instructions
- upc_valid  in  1  upc and offsets valid
- upc_ready  out  1  decoder accepts upc this cycle
- upc  in  13  micro-op address
- dst_offset_out, dst_offset_in  in  11 each  accumulator loop offsets
- src_offset_out, src_offset_in  in  11 each  input loop offsets
- wgt_offset_out, wgt_offset_in  in  10 each  weight loop offsets
- uop_rd_en  out  1  SRAM read strobe
- uop_rd_addr  out  13  SRAM address, equal to upc
- uop_rd_data  in  32  micro-op word. It is valid the cycle after uop_rd_en and is held until the next uop_rd_en.
- idx_valid  out  1  index triple valid
- idx_ready  in  1  datapath accepts the triple
- acc_idx  out  11  accumulator index
- inp_idx  out  11  input index
- wgt_idx  out  10  weight index

## Operation
- Micro-op fields: acc = [10:0], inp = [21:11], wgt = [31:22].
- Stage 0, on the handshake upc_valid && upc_ready:
  - Drive uop_rd_en=1 and uop_rd_addr=upc.
  - Register s1_valid=1.
  - Register the offset sums: dst_sum = dst_offset_out + dst_offset_in, and likewise src_sum and wgt_sum. Each sum is truncated to its field width.
- Stage 1 to output, when the pipeline advances:
  - acc_idx = acc + dst_sum, inp_idx = inp + src_sum, wgt_idx = wgt + wgt_sum.
  - All additions are modulo 2^width and wrap silently.
  - idx_valid takes the value of s1_valid.
- Advance condition: advance = !idx_valid || idx_ready. upc_ready = advance.
- On a stall:
  - uop_rd_en stays low.
  - The stage 1 registers and the output registers hold.
  - The SRAM holds its data, so stage 1 needs no data capture register.
- uop_rd_en is asserted only on an accepted upc. There are no speculative reads.
- flush clears s1_valid and idx_valid on the next edge and overrides any same-cycle handshake. upc_ready is 0 while flush is high.
- Index data registers are not cleared by flush; only the valid flags are.

## Timing
- Reset values: upc_ready=1 after reset deasserts; all other outputs and all valid flags are 0.
- Latency: upc accepted at edge N gives idx_valid=1 after edge N+1, so the triple is present during cycle N+1 to N+2. That is 2 cycles from upc_valid assertion to idx_valid.
- Throughput is 1 triple per cycle with idx_ready held high.
- Stall: a sustained idx_ready=0 fills both stages (2 entries). upc_ready drops in the same cycle idx_valid=1 && !idx_ready, combinationally.
- Output stability: while idx_valid && !idx_ready, acc_idx, inp_idx and wgt_idx are stable.
- Reset mid-operation: all in-flight entries are discarded and no read strobe is issued during reset.
- Simultaneous idx_ready and a new upc: the output is replaced and stage 1 is refilled in the same edge, with no bubble.

## Configuration
- GEMM_UOP_DECODE_STATS_EN defined:
  - Adds output idx_count [31:0], reset 0.
  - It increments on each idx_valid && idx_ready and saturates at 0xFFFFFFFF.
  - flush does not clear it.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Shared package gemm_pkg holds:
  - Width constants UPC_W=13, ACC_IDX_W=11, INP_IDX_W=11, WGT_IDX_W=10, UOP_W=32.
  - Micro-op field LSB/MSB localparams.
  - A packed uop_t struct with fields wgt, inp, acc.
- Single module. No sub-module is warranted, because the pipeline is two register stages with shared advance logic.

## Test plan
- Single uop: SRAM[0x10]=0x00C0_3005 (acc=5, inp=6, wgt=3), all offsets 1.
  - Required: uop_rd_addr=0x10 at accept; idx_valid 2 cycles later with acc=7, inp=8, wgt=5.
- Streaming: 8 consecutive upcs with idx_ready=1.
  - Required: 8 triples on 8 consecutive cycles, in order, with exactly 8 uop_rd_en pulses.
- Backpressure:
  - Stimulus: hold idx_ready=0 for 5 cycles mid-stream.
  - Required: upc_ready=0 once 2 entries are pending; no uop_rd_en during the stall; outputs stable; no loss or duplication on release.
- Wrap:
  - Stimulus: acc=0x7FF with dst_offset_out=2, dst_offset_in=0; wgt=0x3FF with wgt_offset_in=1.
  - Required: acc_idx=0x001, wgt_idx=0x000.
- Flush/reset:
  - Stimulus: flush with 2 entries pending.
  - Required: idx_valid=0 next cycle and no stale triple afterwards.
  - Stimulus: async rst mid-stream.
  - Required: all valids 0 immediately; first post-reset triple is correct.
- With GEMM_UOP_DECODE_STATS_EN: 10 handshakes plus 3 stalled cycles -> idx_count=10.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared widths, micro-op field positions and the packed micro-op layout for the GEMM core.
package gemm_pkg;

  localparam int UPC_W     = 13;
  localparam int ACC_IDX_W = 11;
  localparam int INP_IDX_W = 11;
  localparam int WGT_IDX_W = 10;
  localparam int UOP_W     = 32;

  localparam int ACC_LSB = 0;
  localparam int ACC_MSB = ACC_LSB + ACC_IDX_W - 1;
  localparam int INP_LSB = ACC_MSB + 1;
  localparam int INP_MSB = INP_LSB + INP_IDX_W - 1;
  localparam int WGT_LSB = INP_MSB + 1;
  localparam int WGT_MSB = WGT_LSB + WGT_IDX_W - 1;

  typedef struct packed {
    logic [WGT_IDX_W-1:0] wgt;
    logic [INP_IDX_W-1:0] inp;
    logic [ACC_IDX_W-1:0] acc;
  } uop_t;

endpackage

// File: rtl/gemm_uop_decode.sv
// Micro-op decode: upc -> SRAM read -> offset-adjusted index triple, 2 cycles, full stall on idx_ready=0.
// Optional saturating handshake counter idx_count when GEMM_UOP_DECODE_STATS_EN is defined.
module gemm_uop_decode
  import gemm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 upc_valid,
  output logic                 upc_ready,
  input  logic [UPC_W-1:0]     upc,
  input  logic [ACC_IDX_W-1:0] dst_offset_out,
  input  logic [ACC_IDX_W-1:0] dst_offset_in,
  input  logic [INP_IDX_W-1:0] src_offset_out,
  input  logic [INP_IDX_W-1:0] src_offset_in,
  input  logic [WGT_IDX_W-1:0] wgt_offset_out,
  input  logic [WGT_IDX_W-1:0] wgt_offset_in,
  output logic                 uop_rd_en,
  output logic [UPC_W-1:0]     uop_rd_addr,
  input  logic [UOP_W-1:0]     uop_rd_data,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic [ACC_IDX_W-1:0] acc_idx,
  output logic [INP_IDX_W-1:0] inp_idx,
  output logic [WGT_IDX_W-1:0] wgt_idx
`ifdef GEMM_UOP_DECODE_STATS_EN
  ,
  output logic [31:0]          idx_count
`endif
);

  logic                 w_advance;
  logic                 w_accept;
  uop_t                 w_uop;
  logic [ACC_IDX_W-1:0] w_dst_sum;
  logic [INP_IDX_W-1:0] w_src_sum;
  logic [WGT_IDX_W-1:0] w_wgt_sum;

  logic                 r_s1_valid;
  logic [ACC_IDX_W-1:0] r_dst_sum;
  logic [INP_IDX_W-1:0] r_src_sum;
  logic [WGT_IDX_W-1:0] r_wgt_sum;
  logic                 r_idx_valid;
  logic [ACC_IDX_W-1:0] r_acc_idx;
  logic [INP_IDX_W-1:0] r_inp_idx;
  logic [WGT_IDX_W-1:0] r_wgt_idx;

  // Gating with rst keeps the read strobe quiet while the pipeline is held in reset.
  assign w_advance   = !r_idx_valid || idx_ready;
  assign upc_ready   = w_advance && !flush && !rst;
  assign w_accept    = upc_valid && upc_ready;
  assign uop_rd_en   = w_accept;
  assign uop_rd_addr = upc;

  assign w_uop.acc = uop_rd_data[ACC_MSB:ACC_LSB];
  assign w_uop.inp = uop_rd_data[INP_MSB:INP_LSB];
  assign w_uop.wgt = uop_rd_data[WGT_MSB:WGT_LSB];

  assign w_dst_sum = dst_offset_out + dst_offset_in;
  assign w_src_sum = src_offset_out + src_offset_in;
  assign w_wgt_sum = wgt_offset_out + wgt_offset_in;

  // SRAM data stays put until the next read, so stage 1 consumes it directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_dst_sum   <= '0;
      r_src_sum   <= '0;
      r_wgt_sum   <= '0;
      r_idx_valid <= 1'b0;
      r_acc_idx   <= '0;
      r_inp_idx   <= '0;
      r_wgt_idx   <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_idx_valid <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid  <= w_accept;
      r_idx_valid <= r_s1_valid;
      if (w_accept) begin
        r_dst_sum <= w_dst_sum;
        r_src_sum <= w_src_sum;
        r_wgt_sum <= w_wgt_sum;
      end
      if (r_s1_valid) begin
        r_acc_idx <= w_uop.acc + r_dst_sum;
        r_inp_idx <= w_uop.inp + r_src_sum;
        r_wgt_idx <= w_uop.wgt + r_wgt_sum;
      end
    end
  end

  assign idx_valid = r_idx_valid;
  assign acc_idx   = r_acc_idx;
  assign inp_idx   = r_inp_idx;
  assign wgt_idx   = r_wgt_idx;

`ifdef GEMM_UOP_DECODE_STATS_EN
  logic [31:0] r_idx_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx_count <= '0;
    end else if (r_idx_valid && idx_ready && (r_idx_count != 32'hFFFF_FFFF)) begin
      r_idx_count <= r_idx_count + 32'd1;
    end
  end

  assign idx_count = r_idx_count;
`endif

endmodule

// File: tb/tb_gemm_uop_decode.sv
// Bench for gemm_uop_decode: directed steps plus a random phase, checked against a queue-based triple model.
module tb_gemm_uop_decode;
  import gemm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        upc_valid = 1'b0;
  logic        upc_ready;
  logic [12:0] upc = '0;
  logic [10:0] dst_offset_out = '0, dst_offset_in = '0;
  logic [10:0] src_offset_out = '0, src_offset_in = '0;
  logic [9:0]  wgt_offset_out = '0, wgt_offset_in = '0;
  logic        uop_rd_en;
  logic [12:0] uop_rd_addr;
  logic [31:0] uop_rd_data = '0;
  logic        idx_valid;
  logic        idx_ready = 1'b1;
  logic [10:0] acc_idx;
  logic [10:0] inp_idx;
  logic [9:0]  wgt_idx;
`ifdef GEMM_UOP_DECODE_STATS_EN
  logic [31:0] idx_count;
`endif

  gemm_uop_decode dut (
    .clk(clk), .rst(rst), .flush(flush),
    .upc_valid(upc_valid), .upc_ready(upc_ready), .upc(upc),
    .dst_offset_out(dst_offset_out), .dst_offset_in(dst_offset_in),
    .src_offset_out(src_offset_out), .src_offset_in(src_offset_in),
    .wgt_offset_out(wgt_offset_out), .wgt_offset_in(wgt_offset_in),
    .uop_rd_en(uop_rd_en), .uop_rd_addr(uop_rd_addr), .uop_rd_data(uop_rd_data),
    .idx_valid(idx_valid), .idx_ready(idx_ready),
    .acc_idx(acc_idx), .inp_idx(inp_idx), .wgt_idx(wgt_idx)
`ifdef GEMM_UOP_DECODE_STATS_EN
    , .idx_count(idx_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:8191];
  always @(posedge clk) if (uop_rd_en) uop_rd_data <= mem[uop_rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [10:0] a;
    logic [10:0] i;
    logic [9:0]  w;
  } trip_t;
  trip_t q[$];

  function automatic trip_t exp_of(input logic [12:0] addr);
    int unsigned word;
    trip_t t;
    word = mem[addr];
    t.a = 11'(((word % 2048) + dst_offset_out + dst_offset_in) % 2048);
    t.i = 11'((((word / 2048) % 2048) + src_offset_out + src_offset_in) % 2048);
    t.w = 10'(((word / 4194304) + wgt_offset_out + wgt_offset_in) % 1024);
    return t;
  endfunction

  int n_rd = 0, n_out = 0, streak = 0, max_streak = 0;
  logic prev_stall = 1'b0;
  logic [10:0] p_a, p_i;
  logic [9:0]  p_w;

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    trip_t t;
    if (rst) begin
      chk("rd_en_in_reset", 32'(uop_rd_en), 32'd0);
      q.delete();
      prev_stall = 1'b0;
      streak = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(idx_valid), 32'd1);
        chk("stall_acc", 32'(acc_idx), 32'(p_a));
        chk("stall_inp", 32'(inp_idx), 32'(p_i));
        chk("stall_wgt", 32'(wgt_idx), 32'(p_w));
      end
      chk("upc_ready", 32'(upc_ready), 32'(!flush && (!idx_valid || idx_ready)));
      chk("rd_en_only_on_accept", 32'(uop_rd_en), 32'(upc_valid && upc_ready));
      if (uop_rd_en) begin
        n_rd++;
        chk("rd_addr", 32'(uop_rd_addr), 32'(upc));
      end
      if (idx_valid && idx_ready) begin
        n_out++;
        streak++;
        if (q.size() == 0) begin
          chk("unexpected_triple", 32'(idx_valid), 32'd0);
        end else begin
          t = q.pop_front();
          chk("sb_acc", 32'(acc_idx), 32'(t.a));
          chk("sb_inp", 32'(inp_idx), 32'(t.i));
          chk("sb_wgt", 32'(wgt_idx), 32'(t.w));
        end
      end else begin
        streak = 0;
      end
      if (streak > max_streak) max_streak = streak;
      if (upc_valid && upc_ready) q.push_back(exp_of(upc));
      if (flush) q.delete();
      prev_stall = idx_valid && !idx_ready && !flush;
      p_a = acc_idx;
      p_i = inp_idx;
      p_w = wgt_idx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_offs(input logic [10:0] d0, d1, s0, s1, input logic [9:0] w0, w1);
    dst_offset_out = d0; dst_offset_in = d1;
    src_offset_out = s0; src_offset_in = s1;
    wgt_offset_out = w0; wgt_offset_in = w1;
  endtask

  task automatic rand_offs();
    set_offs(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom), 10'($urandom), 10'($urandom));
  endtask

  initial begin
    int rd0, out0, acc_n, ci;
    for (int k = 0; k < 8192; k++) mem[k] = $urandom;
    mem[16] = 32'h00C0_3005;
    mem[17] = 32'hFFC0_07FF;

    repeat (3) tick();
    chk("reset_idx_valid", 32'(idx_valid), 32'd0);
    chk("reset_rd_en", 32'(uop_rd_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_upc_ready", 32'(upc_ready), 32'd1);
    chk("reset_acc", 32'(acc_idx), 32'd0);
    chk("reset_inp", 32'(inp_idx), 32'd0);
    chk("reset_wgt", 32'(wgt_idx), 32'd0);

    // Single micro-op, all offsets 1.
    set_offs(1, 1, 1, 1, 1, 1);
    upc = 13'h10;
    upc_valid = 1'b1;
    #1;
    chk("single_rd_en", 32'(uop_rd_en), 32'd1);
    chk("single_rd_addr", 32'(uop_rd_addr), 32'h10);
    tick();
    upc_valid = 1'b0;
    chk("single_not_yet", 32'(idx_valid), 32'd0);
    tick();
    chk("single_valid", 32'(idx_valid), 32'd1);
    chk("single_acc", 32'(acc_idx), 32'd7);
    chk("single_inp", 32'(inp_idx), 32'd8);
    chk("single_wgt", 32'(wgt_idx), 32'd5);
    tick();

    // Streaming: 8 back-to-back micro-ops.
    repeat (2) tick();
    max_streak = 0;
    rd0 = n_rd;
    out0 = n_out;
    upc_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      upc = 13'($urandom);
      rand_offs();
      tick();
    end
    upc_valid = 1'b0;
    repeat (4) tick();
    chk("stream_rd_pulses", 32'(n_rd - rd0), 32'd8);
    chk("stream_outputs", 32'(n_out - out0), 32'd8);
    chk("stream_consecutive", 32'(max_streak), 32'd8);

    // Backpressure for 5 cycles mid-stream.
    upc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      upc = 13'($urandom);
      rand_offs();
      tick();
    end
    idx_ready = 1'b0;
    rd0 = n_rd;
    for (int k = 0; k < 5; k++) begin
      upc = 13'($urandom);
      #1;
      chk("bp_upc_ready", 32'(upc_ready), 32'd0);
      chk("bp_idx_valid", 32'(idx_valid), 32'd1);
      tick();
    end
    chk("bp_no_reads", 32'(n_rd - rd0), 32'd0);
    idx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      upc = 13'($urandom);
      rand_offs();
      tick();
    end
    upc_valid = 1'b0;
    repeat (4) tick();
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Wrap of accumulator and weight sums.
    set_offs(2, 0, 0, 0, 0, 1);
    upc = 13'h11;
    upc_valid = 1'b1;
    tick();
    upc_valid = 1'b0;
    tick();
    chk("wrap_valid", 32'(idx_valid), 32'd1);
    chk("wrap_acc", 32'(acc_idx), 32'h001);
    chk("wrap_inp", 32'(inp_idx), 32'h000);
    chk("wrap_wgt", 32'(wgt_idx), 32'h000);
    tick();

    // Flush with both stages occupied.
    idx_ready = 1'b0;
    upc_valid = 1'b1;
    upc = 13'($urandom);
    tick();
    upc = 13'($urandom);
    tick();
    chk("flush_pre_valid", 32'(idx_valid), 32'd1);
    chk("flush_pre_full", 32'(upc_ready), 32'd0);
    upc_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears", 32'(idx_valid), 32'd0);
    idx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_stale", 32'(idx_valid), 32'd0);
    end

    // Asynchronous reset mid-stream.
    upc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      upc = 13'($urandom);
      rand_offs();
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_idx_valid", 32'(idx_valid), 32'd0);
    chk("arst_rd_en", 32'(uop_rd_en), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    set_offs(1, 1, 1, 1, 1, 1);
    upc = 13'h10;
    tick();
    upc_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(idx_valid), 32'd1);
    chk("post_rst_acc", 32'(acc_idx), 32'd7);
    chk("post_rst_inp", 32'(inp_idx), 32'd8);
    chk("post_rst_wgt", 32'(wgt_idx), 32'd5);
    tick();

`ifdef GEMM_UOP_DECODE_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats_reset", idx_count, 32'd0);
    acc_n = 0;
    ci = 0;
    upc_valid = 1'b1;
    while (acc_n < 10 && ci < 100) begin
      idx_ready = !(ci >= 4 && ci < 7);
      upc = 13'($urandom);
      #1;
      if (upc_ready) acc_n++;
      tick();
      ci++;
    end
    upc_valid = 1'b0;
    idx_ready = 1'b1;
    repeat (4) tick();
    chk("stats_accepts", 32'(acc_n), 32'd10);
    chk("stats_count", idx_count, 32'd10);
`endif

    // Random traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      upc_valid = 1'($urandom_range(0, 1));
      idx_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      upc = 13'($urandom);
      rand_offs();
      tick();
    end
    flush = 1'b0;
    upc_valid = 1'b0;
    idx_ready = 1'b1;
    repeat (4) tick();
    chk("random_drained", 32'(q.size()), 32'd0);
    chk("random_idle", 32'(idx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
